// File: rtl/hiscore_pkg.sv
// Shared definitions for the high-score save/restore bridge: FSM states,
// the byte returned for reads past the window, and the hps_io index used by CONF_STR.
package hiscore_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } hs_state_t;

    localparam logic [7:0] FILL_BYTE     = 8'hFF;
    localparam logic [7:0] HISCORE_INDEX = 8'd4;

endpackage

// File: rtl/hiscore_upload.sv
// Bridges the hps_io ioctl channel to the second port of the game's work RAM so the
// high-score window can be uploaded (saved) and downloaded (restored).
module hiscore_upload
    import hiscore_pkg::*;
#(
    parameter int                ADDR_W = 10,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter int                SIZE   = 64,
    parameter logic [7:0]        INDEX  = HISCORE_INDEX,
    parameter int                RD_LAT = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic              ioctl_wr,
    input  logic              ioctl_rd,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout,
    output logic              restored,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    localparam logic [1:0]  LAT_INIT = 2'(RD_LAT);
    localparam logic [8:0]  SIZE_C   = 9'(SIZE);
    localparam logic [24:0] SIZE_A   = 25'(SIZE);

    logic              act_dn;
    logic              act_up;
    logic              act_dn_q;
    logic              in_range;
    logic [ADDR_W-1:0] win_addr;

    hs_state_t         state_q;
    hs_state_t         state_d;
    logic [1:0]        lat_q;
    logic [1:0]        lat_d;
    logic              rd_accept;
    logic              rd_fill;
    logic              wr_accept;
    logic [8:0]        wr_cnt;

    always_comb begin
        act_dn   = ioctl_download && (ioctl_index == INDEX);
        act_up   = ioctl_upload && (ioctl_index == INDEX) && !act_dn;
        in_range = ioctl_addr < SIZE_A;
        win_addr = BASE + ADDR_W'(ioctl_addr[7:0]);
    end

    // Upload handshake: ioctl_rd is a one-cycle request; this block answers by raising
    // ioctl_wait the following cycle and holds it until ioctl_din carries the byte.
    // hps_io must not issue another ioctl_rd while ioctl_wait is high.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        rd_accept = 1'b0;
        rd_fill   = 1'b0;
        wr_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (act_up && ioctl_rd) begin
                    if (in_range) begin
                        rd_accept = 1'b1;
                        lat_d     = LAT_INIT;
                        state_d   = RD_WAIT;
                    end else begin
                        rd_fill = 1'b1;
                    end
                end
                if (act_dn && ioctl_wr && in_range) begin
                    wr_accept = 1'b1;
                end
            end
            RD_WAIT: begin
                lat_d = lat_q - 2'd1;
                if (lat_q <= 2'd1) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_q      <= 2'd0;
            ioctl_wait <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            ioctl_wait <= (state_d != IDLE);
        end
    end

    // One RAM port serves both directions; the FSM guarantees they never coincide.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_din   <= 8'd0;
            ram_we    <= 1'b0;
            ioctl_din <= 8'd0;
        end else begin
            ram_we <= wr_accept;
            if (rd_accept || wr_accept) begin
                ram_addr <= win_addr;
            end
            if (wr_accept) begin
                ram_din <= ioctl_dout;
            end
            if (rd_fill) begin
                ioctl_din <= FILL_BYTE;
            end else if (state_q == RD_DONE) begin
                ioctl_din <= ram_dout;
            end
        end
    end

    // A restore only counts when every byte of the window arrived in one download.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            act_dn_q <= 1'b0;
            wr_cnt   <= 9'd0;
            restored <= 1'b0;
        end else begin
            act_dn_q <= act_dn;
            if (act_dn && !act_dn_q) begin
                wr_cnt <= wr_accept ? 9'd1 : 9'd0;
            end else if (wr_accept && (wr_cnt != SIZE_C)) begin
                wr_cnt <= wr_cnt + 9'd1;
            end
            if (!act_dn && act_dn_q && (wr_cnt == SIZE_C)) begin
                restored <= 1'b1;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_hiscore_upload.sv
// Directed bench for hiscore_upload: two instances (RAM latency 1 and 3) share the
// ioctl stimulus, each backed by its own behavioural work-RAM model.
module tb_hiscore_upload;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic        ioctl_wr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_dout;

    logic [7:0]  ioctl_din1, ioctl_din3;
    logic        ioctl_wait1, ioctl_wait3;
    logic [9:0]  ram_addr1, ram_addr3;
    logic [7:0]  ram_din1, ram_din3;
    logic        ram_we1, ram_we3;
    logic [7:0]  ram_dout1, ram_dout3;
    logic        restored1, restored3;
    logic        busy1, busy3;
    logic [1:0]  state_dbg1, state_dbg3;

    logic [7:0]  mem1 [0:1023];
    logic [7:0]  mem3 [0:1023];
    logic [7:0]  p0, p1, p2;

    int n_cmp  = 0;
    int n_fail = 0;
    int we_cnt = 0;
    logic [17:0] exp_q[$];

    always #5 clk_sys = ~clk_sys;

    hiscore_upload #(.RD_LAT(1)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_dout(ioctl_dout),
        .ioctl_din(ioctl_din1), .ioctl_wait(ioctl_wait1),
        .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_we(ram_we1), .ram_dout(ram_dout1),
        .restored(restored1), .busy(busy1), .state_dbg(state_dbg1)
    );

    hiscore_upload #(.RD_LAT(3)) dut3 (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_dout(ioctl_dout),
        .ioctl_din(ioctl_din3), .ioctl_wait(ioctl_wait3),
        .ram_addr(ram_addr3), .ram_din(ram_din3), .ram_we(ram_we3), .ram_dout(ram_dout3),
        .restored(restored3), .busy(busy3), .state_dbg(state_dbg3)
    );

    // Synchronous RAMs: one register stage for dut, three for dut3.
    always @(posedge clk_sys) begin
        if (ram_we1) mem1[ram_addr1] <= ram_din1;
        ram_dout1 <= mem1[ram_addr1];
    end

    always @(posedge clk_sys) begin
        if (ram_we3) mem3[ram_addr3] <= ram_din3;
        p0 <= mem3[ram_addr3];
        p1 <= p0;
        p2 <= p1;
    end
    assign ram_dout3 = p2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every RAM write of dut must match the next expected {addr, data}.
    always @(negedge clk_sys) begin
        if (ram_we1) begin
            we_cnt++;
            check("we_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("we_addr_data", 32'({ram_addr1, ram_din1}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Opens a download at idx, streams n back-to-back bytes from first, closes it.
    task automatic dl_session(input logic [7:0] idx, input int first, input int n,
                              input logic [7:0] xr);
        logic [7:0] d;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            d          = 8'(first + i) ^ xr;
            ioctl_addr = 25'(first + i);
            ioctl_dout = d;
            ioctl_wr   = 1'b1;
            if (idx == 8'd4 && (first + i) < 64) exp_q.push_back({10'(first + i), d});
            tick();
        end
        ioctl_wr = 1'b0;
        tick();
        ioctl_download = 1'b0;
    endtask

    task automatic do_rd(input logic [24:0] a);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
    endtask

    // Issues an in-range read and measures the wait-high cycles on both instances.
    task automatic read_check(input string tag, input logic [24:0] a, input logic [7:0] exp);
        int w1;
        int w3;
        do_rd(a);
        @(negedge clk_sys);
        check({tag, "_wait_set"}, 32'(ioctl_wait1), 32'd1);
        check({tag, "_busy"}, 32'(busy1), 32'd1);
        check({tag, "_ram_addr"}, 32'(ram_addr1), 32'(a));
        w1 = int'(ioctl_wait1);
        w3 = int'(ioctl_wait3);
        repeat (7) begin
            @(negedge clk_sys);
            w1 += int'(ioctl_wait1);
            w3 += int'(ioctl_wait3);
        end
        check({tag, "_wait_cycles_lat1"}, 32'(w1), 32'd2);
        check({tag, "_wait_cycles_lat3"}, 32'(w3), 32'd4);
        check({tag, "_din_lat1"}, 32'(ioctl_din1), 32'(exp));
        check({tag, "_din_lat3"}, 32'(ioctl_din3), 32'(exp));
        check({tag, "_idle"}, 32'(busy1 | busy3), 32'd0);
    endtask

    initial begin
        int we_before;
        int wsum;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = 25'd0;
        ioctl_wr       = 1'b0;
        ioctl_rd       = 1'b0;
        ioctl_dout     = 8'd0;

        // Reset state
        repeat (2) @(posedge clk_sys);
        #1 reset = 1'b0;
        @(negedge clk_sys);
        check("rst_din", 32'(ioctl_din1), 32'd0);
        check("rst_wait", 32'(ioctl_wait1), 32'd0);
        check("rst_ram_addr", 32'(ram_addr1), 32'd0);
        check("rst_ram_din", 32'(ram_din1), 32'd0);
        check("rst_ram_we", 32'(ram_we1), 32'd0);
        check("rst_restored", 32'(restored1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_state", 32'(state_dbg1), 32'd0);

        // Full restore plus one dropped byte at address 64
        dl_session(8'd4, 0, 65, 8'h00);
        @(negedge clk_sys);
        check("full_restored_not_yet", 32'(restored1), 32'd0);
        @(negedge clk_sys);
        check("full_restored", 32'(restored1), 32'd1);
        check("full_restored_lat3", 32'(restored3), 32'd1);
        check("full_we_count", 32'(we_cnt), 32'd64);
        check("full_queue_empty", 32'(exp_q.size()), 32'd0);
        check("full_mem_3f", 32'(mem1[63]), 32'h3F);

        // Partial download leaves restored clear
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst2_restored", 32'(restored1), 32'd0);
        dl_session(8'd4, 0, 40, 8'h00);
        repeat (3) @(negedge clk_sys);
        check("partial_restored", 32'(restored1), 32'd0);
        check("partial_we_count", 32'(we_cnt), 32'd104);

        // Foreign index: no RAM writes at all
        we_before = we_cnt;
        dl_session(8'd0, 0, 64, 8'h00);
        repeat (3) @(negedge clk_sys);
        check("foreign_we_count", 32'(we_cnt - we_before), 32'd0);
        check("foreign_restored", 32'(restored1), 32'd0);

        // Seed RAM[5]=A5 with a single-byte download
        dl_session(8'd4, 5, 1, 8'hA0);
        repeat (2) @(negedge clk_sys);
        check("seed_restored", 32'(restored1), 32'd0);
        check("seed_queue_empty", 32'(exp_q.size()), 32'd0);

        // Uploads in range, including the last window byte
        #1;
        ioctl_index  = 8'd4;
        ioctl_upload = 1'b1;
        read_check("up5", 25'd5, 8'hA5);
        #1;
        read_check("up63", 25'd63, 8'h3F);

        // Out of range: immediate fill byte, no wait, RAM address untouched
        #1;
        do_rd(25'd64);
        @(negedge clk_sys);
        check("oor_din", 32'(ioctl_din1), 32'hFF);
        check("oor_din_lat3", 32'(ioctl_din3), 32'hFF);
        check("oor_ram_addr", 32'(ram_addr1), 32'd63);
        wsum = int'(ioctl_wait1) + int'(ioctl_wait3);
        repeat (3) begin
            @(negedge clk_sys);
            wsum += int'(ioctl_wait1) + int'(ioctl_wait3);
        end
        check("oor_wait_never", 32'(wsum), 32'd0);

        // Wrong index upload is ignored
        #1;
        ioctl_index = 8'd1;
        do_rd(25'd5);
        @(negedge clk_sys);
        check("foreign_rd_wait", 32'(ioctl_wait1), 32'd0);
        check("foreign_rd_din", 32'(ioctl_din1), 32'hFF);
        ioctl_index = 8'd4;

        // Reset in the cycle after the read request
        #1;
        do_rd(25'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk_sys);
        check("midrst_wait", 32'(ioctl_wait1), 32'd0);
        check("midrst_wait_lat3", 32'(ioctl_wait3), 32'd0);
        check("midrst_din", 32'(ioctl_din1), 32'd0);
        check("midrst_busy", 32'(busy1 | busy3), 32'd0);
        repeat (4) @(negedge clk_sys);
        check("midrst_no_capture", 32'(ioctl_din1), 32'd0);
        check("midrst_no_capture_lat3", 32'(ioctl_din3), 32'd0);
        #1;
        read_check("after_rst", 25'd5, 8'hA5);

        ioctl_upload = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hiscore_upload.md
# hiscore_upload

Bridges the MiSTer `hps_io` file-transfer channel to the game's work RAM so the high-score table can be saved and restored. It sits beside the ROM loader in the emu top. A save is an `ioctl` upload: this block acts as the read responder, supplies `ioctl_din` and stretches `ioctl_wait`. A restore is an `ioctl` download: this block writes the incoming bytes into a fixed RAM window. It owns the second port of a dual-port work RAM, so the CPU is never stalled.

## Interface

Parameters:
- `ADDR_W`, default 10, width of the work RAM address.
- `BASE`, default 10'h000, first RAM address of the high-score window.
- `SIZE`, default 64, window length in bytes, range 1..256.
- `INDEX`, default 8'd4, `ioctl_index` value this block responds to.
- `RD_LAT`, default 1, RAM read latency in cycles, range 1..3.

Ports:
- `clk_sys` in 1: system clock, same clock as `hps_io`.
- `reset` in 1: synchronous, active-high.
- `ioctl_download` in 1: download in progress.
- `ioctl_upload` in 1: upload in progress.
- `ioctl_index` in 8: transfer index.
- `ioctl_addr` in 25: byte address within the file.
- `ioctl_wr` in 1: download byte strobe.
- `ioctl_rd` in 1: upload byte request strobe.
- `ioctl_dout` in 8: download data.
- `ioctl_din` out 8: upload data.
- `ioctl_wait` out 1: upload stall request to `hps_io`.
- `ram_addr` out ADDR_W: RAM port address.
- `ram_din` out 8: RAM write data.
- `ram_we` out 1: RAM write enable, one-cycle pulse.
- `ram_dout` in 8: RAM read data.
- `restored` out 1: sticky; a complete image was restored.
- `busy` out 1: FSM is not in IDLE.

## Operation

- Activity qualifiers:
  - `act_dn` = `ioctl_download` & (`ioctl_index` == INDEX).
  - `act_up` = `ioctl_upload` & (`ioctl_index` == INDEX) & !`act_dn`.
  - Download has priority over upload.
- An address is in range when `ioctl_addr` < SIZE. The RAM address is BASE + `ioctl_addr`[7:0], truncated to ADDR_W bits, so it wraps modulo 2^ADDR_W.
- FSM states are IDLE, RD_WAIT and RD_DONE.
  - IDLE, `act_up` & `ioctl_rd` & in range: register `ram_addr`, set `ioctl_wait`=1, load the latency counter with RD_LAT, go to RD_WAIT.
  - IDLE, `act_up` & `ioctl_rd` & out of range: set `ioctl_din`=8'hFF. `ioctl_wait` stays 0 and the FSM stays in IDLE.
  - RD_WAIT: decrement the counter each cycle. When it reaches 0, go to RD_DONE.
  - RD_DONE: capture `ioctl_din` <= `ram_dout`, clear `ioctl_wait`, return to IDLE.
  - Any `ioctl_rd` arriving while not in IDLE is ignored; the protocol forbids it.
- Restore path, active in IDLE only: `act_dn` & `ioctl_wr` & in range registers `ram_addr`, `ram_din` <= `ioctl_dout` and `ram_we`=1 for exactly one cycle. Out-of-range writes are dropped with no RAM write.
- Write counter, 9 bits:
  - Cleared on the rising edge of `act_dn`.
  - Increments on each in-range write and saturates at SIZE.
  - On the falling edge of `act_dn`, if count == SIZE, set `restored`=1. It stays set until `reset`.
  - A short or partial download leaves `restored` unchanged.
- `busy`=1 in RD_WAIT and RD_DONE.

## Timing

- Reset values: `ioctl_din`=0, `ioctl_wait`=0, `ram_addr`=0, `ram_din`=0, `ram_we`=0, `restored`=0, `busy`=0, FSM=IDLE, counters=0.
- Upload, with `ioctl_rd` sampled at clock edge N:
  - `ioctl_wait`=1 and `ram_addr` are valid after edge N.
  - The RAM output is valid RD_LAT edges later.
  - `ioctl_din` is captured and `ioctl_wait`=0 after edge N+RD_LAT+1.
  - `ioctl_wait` is therefore high for exactly RD_LAT+1 cycles; for RD_LAT=1 that is 2 cycles.
- Out-of-range upload: `ioctl_din`=FF is valid after edge N; zero wait cycles.
- Download, with `ioctl_wr` sampled at edge N: `ram_we` is high during cycle N+1 only.
- Back-to-back `ioctl_wr` on consecutive cycles is supported: one RAM write per cycle, no drops.
- `reset` asserted in RD_WAIT or RD_DONE: `ioctl_wait`=0 and FSM=IDLE after that edge. No capture takes place.
- `act_dn` edge detection uses a registered copy of `act_dn`, so the `restored` flag appears one cycle after `ioctl_download` falls.

## Structure

- Shared package `hiscore_pkg` holds:
  - The FSM state enum (IDLE, RD_WAIT, RD_DONE).
  - The `FILL_BYTE` = 8'hFF constant.
  - The default INDEX constant, so the emu top's CONF_STR and this block agree.
- No sub-module; a single module is natural. The edge detector and counters are inline.

## Test plan

- Reset: assert `reset` for 2 cycles → every output is 0 and `busy`=0.
- Full restore: index 4, 64 writes, `ioctl_dout`=`addr`, back-to-back → 64 `ram_we` pulses at RAM addresses 0x000..0x03F with data 0x00..0x3F; `restored`=1 one cycle after `ioctl_download` falls.
- Partial or foreign download:
  - 40 bytes at index 4 → `restored` stays 0.
  - 64 bytes at index 0 → zero `ram_we` pulses.
- Upload, in range: RAM[5]=0xA5, RD_LAT=1, `ioctl_rd` at `addr` 5 → `ioctl_wait` high for exactly 2 cycles, then `ioctl_din`=0xA5. With RD_LAT=3, `ioctl_wait` is high for 4 cycles.
- Upload, out of range: `ioctl_rd` at `addr` 64 → `ioctl_din`=0xFF the next cycle, `ioctl_wait` never asserted, no `ram_addr` change.
- Reset mid-read: pulse `reset` in the cycle after `ioctl_rd` → `ioctl_wait`=0 the next cycle, `ioctl_din`=0, then a fresh `ioctl_rd` is served normally.
